// File: rtl/ifetch_queue_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_queue_if : redirect, I-cache and decode-side signals          |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
interface ifetch_queue_if;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        to_icache_req_valid;
   logic [31:0] to_icache_req_addr;
   logic        from_icache_req_ready;
   logic        from_icache_rsp_valid;
   logic [31:0] from_icache_rsp_data;
   logic        to_icache_rsp_ready;
   logic        out_valid;
   logic [31:0] out_inst;
   logic [31:0] out_pc;
   logic        out_ready;

   // master is the fetch queue, slave is the surrounding pipeline/cache
   modport master (
      input  redirect_valid, redirect_pc, from_icache_req_ready,
             from_icache_rsp_valid, from_icache_rsp_data, out_ready,
      output to_icache_req_valid, to_icache_req_addr, to_icache_rsp_ready,
             out_valid, out_inst, out_pc
   );

   modport slave (
      output redirect_valid, redirect_pc, from_icache_req_ready,
             from_icache_rsp_valid, from_icache_rsp_data, out_ready,
      input  to_icache_req_valid, to_icache_req_addr, to_icache_rsp_ready,
             out_valid, out_inst, out_pc
   );
endinterface
`default_nettype wire

// File: rtl/ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | ifetch_queue : single-outstanding I-cache fetcher with FIFO to decode |
// | Optional macro IFQ_BYPASS_EN: empty-queue response bypass to out_*.  |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module ifetch_queue #(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          DEPTH    = 4
) (
   input wire              clk,
   input wire              rst,
   ifetch_queue_if.master  bus
);

   localparam int             PW      = $clog2(DEPTH);
   localparam int             CW      = $clog2(DEPTH + 1);
   localparam logic [CW-1:0]  DEPTH_C = CW'(DEPTH);

   typedef enum logic [1:0] {
      S_REQ      = 2'd0,
      S_WAIT_RSP = 2'd1,
      S_DISCARD  = 2'd2
   } state_e;

   state_e          state_q;
   logic [31:0]     fetch_addr_q;
   logic [31:0]     pend_pc_q;
   logic [31:0]     pc_mem_q   [DEPTH];
   logic [31:0]     inst_mem_q [DEPTH];
   logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
   logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
   logic [CW-1:0]   count_q,  count_d;

   logic [31:0]     next_pc;
   logic            q_nonempty;
   logic            req_valid;
   logic            rsp_ready;
   logic            req_hs;
   logic            rsp_hs;
   logic            rsp_accept;
   logic            byp_vld;
   logic            push;
   logic            pop;

   assign next_pc    = {bus.redirect_pc[31:2], 2'b00};
   assign q_nonempty = (count_q != '0);
   // rst gate keeps req_valid low in the reset cycle, when state already reads REQ
   assign req_valid  = ~rst && (state_q == S_REQ) && (count_q < DEPTH_C);
   assign rsp_ready  = (state_q != S_REQ);
   assign req_hs     = req_valid & bus.from_icache_req_ready;
   assign rsp_hs     = rsp_ready & bus.from_icache_rsp_valid;
   assign rsp_accept = (state_q == S_WAIT_RSP) & rsp_hs & ~bus.redirect_valid;

`ifdef IFQ_BYPASS_EN
   assign byp_vld = rsp_accept & ~q_nonempty;
`else
   assign byp_vld = 1'b0;
`endif

   assign push = rsp_accept & ~(byp_vld & bus.out_ready);
   assign pop  = q_nonempty & bus.out_ready;

   assign bus.to_icache_req_valid = req_valid;
   assign bus.to_icache_req_addr  = fetch_addr_q;
   assign bus.to_icache_rsp_ready = rsp_ready;
   assign bus.out_valid = q_nonempty | byp_vld;
   assign bus.out_pc    = q_nonempty ? pc_mem_q[rd_ptr_q]
                        : (byp_vld ? fetch_addr_q : 32'h0);
   assign bus.out_inst  = q_nonempty ? inst_mem_q[rd_ptr_q]
                        : (byp_vld ? bus.from_icache_rsp_data : 32'h0);

   always_comb begin
      count_d  = count_q;
      rd_ptr_d = rd_ptr_q;
      wr_ptr_d = wr_ptr_q;
      if (bus.redirect_valid) begin
         count_d  = '0;
         rd_ptr_d = '0;
         wr_ptr_d = '0;
      end else begin
         count_d  = count_q + CW'(push) - CW'(pop);
         rd_ptr_d = rd_ptr_q + PW'(pop);
         wr_ptr_d = wr_ptr_q + PW'(push);
      end
   end

   always_ff @(posedge clk) begin
      if (push) begin
         pc_mem_q[wr_ptr_q]   <= fetch_addr_q;
         inst_mem_q[wr_ptr_q] <= bus.from_icache_rsp_data;
      end
   end

   // fetch_addr only moves while no request is in flight, so the cache sees a stable address
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q      <= S_REQ;
         fetch_addr_q <= RESET_PC;
         pend_pc_q    <= 32'h0;
         count_q      <= '0;
         rd_ptr_q     <= '0;
         wr_ptr_q     <= '0;
      end else begin
         count_q  <= count_d;
         rd_ptr_q <= rd_ptr_d;
         wr_ptr_q <= wr_ptr_d;
         case (state_q)
            S_REQ: begin
               if (bus.redirect_valid) begin
                  if (req_hs) begin
                     state_q   <= S_DISCARD;
                     pend_pc_q <= next_pc;
                  end else begin
                     fetch_addr_q <= next_pc;
                  end
               end else if (req_hs) begin
                  state_q <= S_WAIT_RSP;
               end
            end
            S_WAIT_RSP: begin
               if (rsp_hs) begin
                  state_q      <= S_REQ;
                  fetch_addr_q <= bus.redirect_valid ? next_pc : fetch_addr_q + 32'd4;
               end else if (bus.redirect_valid) begin
                  state_q   <= S_DISCARD;
                  pend_pc_q <= next_pc;
               end
            end
            S_DISCARD: begin
               if (rsp_hs) begin
                  state_q      <= S_REQ;
                  fetch_addr_q <= bus.redirect_valid ? next_pc : pend_pc_q;
               end else if (bus.redirect_valid) begin
                  pend_pc_q <= next_pc;
               end
            end
            default: state_q <= S_REQ;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_ifetch_queue.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_ifetch_queue : transaction-level model plus directed scenarios    |
// | Rev 1.0                                                              |
// +----------------------------------------------------------------------+
module tb_ifetch_queue;
   localparam int          DEPTH    = 4;
   localparam logic [31:0] RESET_PC = 32'h0000_0000;
`ifdef IFQ_BYPASS_EN
   localparam bit BYP = 1'b1;
`else
   localparam bit BYP = 1'b0;
`endif

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   ifetch_queue_if bus();

   ifetch_queue #(.RESET_PC(RESET_PC), .DEPTH(DEPTH)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   int checks = 0;
   int errors = 0;

   // model: instruction stream after the latest redirect, one tracked transaction
   logic [31:0] mq_pc[$];
   logic [31:0] mq_inst[$];
   bit          outst = 0;
   bit          stale = 0;
   logic [31:0] oaddr = 32'h0;
   logic [31:0] exp_fetch = RESET_PC;

   // behavioural I-cache
   bit          c_busy = 0;
   bit          hold_en = 0;
   logic [31:0] c_addr = 32'h0;
   logic [31:0] hold_addr = 32'h0;
   int          c_lat = 1;
   int          c_cnt = 0;

   bit          rst_at_edge = 1;
   bit          got_req = 0, got_rsp = 0;
   bit          s_req_valid, s_req_hs, s_rsp_valid, s_rsp_ready, s_out_valid;
   logic [31:0] s_req_addr, s_out_pc;
   int          n_req = 0;
   logic [31:0] pop_log[$];

   function automatic logic [31:0] f(input logic [31:0] a);
      return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
   endfunction

   function automatic logic [31:0] logat(input int i);
      return (pop_log.size() > i) ? pop_log[i] : 32'hDEAD_BEEF;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      int sz;
      bit exp_rv, byp_now, qhs, rhs;
      @(negedge clk);
      if (rst) begin
         if (rst_at_edge) begin
            chk("rst_req_valid", bus.to_icache_req_valid, 0);
            chk("rst_rsp_ready", bus.to_icache_rsp_ready, 0);
            chk("rst_out_valid", bus.out_valid, 0);
            chk("rst_out_inst",  bus.out_inst, 0);
            chk("rst_out_pc",    bus.out_pc, 0);
         end
         mq_pc.delete(); mq_inst.delete();
         outst = 0; stale = 0; exp_fetch = RESET_PC;
         got_req = 0; got_rsp = 0;
      end else begin
         sz      = mq_pc.size();
         exp_rv  = !outst && (sz < DEPTH);
         byp_now = BYP && (sz == 0) && outst && !stale &&
                   bus.from_icache_rsp_valid && !bus.redirect_valid;
         chk("req_valid", bus.to_icache_req_valid, exp_rv);
         chk("rsp_ready", bus.to_icache_rsp_ready, outst);
         chk("out_valid", bus.out_valid, (sz != 0) || byp_now);
         if (exp_rv) chk("req_addr", bus.to_icache_req_addr, exp_fetch);
         if (outst)  chk("req_addr_hold", bus.to_icache_req_addr, oaddr);
         if (sz != 0) begin
            chk("out_pc",   bus.out_pc,   mq_pc[0]);
            chk("out_inst", bus.out_inst, mq_inst[0]);
         end else if (byp_now) begin
            chk("byp_pc",   bus.out_pc,   oaddr);
            chk("byp_inst", bus.out_inst, f(oaddr));
         end

         s_req_valid = bus.to_icache_req_valid;
         s_req_addr  = bus.to_icache_req_addr;
         s_rsp_valid = bus.from_icache_rsp_valid;
         s_rsp_ready = bus.to_icache_rsp_ready;
         s_out_valid = bus.out_valid;
         s_out_pc    = bus.out_pc;
         got_req  = bus.to_icache_req_valid && bus.from_icache_req_ready;
         got_rsp  = bus.to_icache_rsp_ready && bus.from_icache_rsp_valid;
         s_req_hs = got_req;
         if (got_req) n_req++;
         if (bus.out_valid && bus.out_ready) pop_log.push_back(bus.out_pc);

         qhs = exp_rv && bus.from_icache_req_ready;
         rhs = outst && bus.from_icache_rsp_valid;
         if (sz != 0 && bus.out_ready) begin
            void'(mq_pc.pop_front());
            void'(mq_inst.pop_front());
         end
         if (rhs) begin
            outst = 0;
            if (!stale && !bus.redirect_valid) begin
               exp_fetch = oaddr + 32'd4;
               if (!(BYP && sz == 0 && bus.out_ready)) begin
                  mq_pc.push_back(oaddr);
                  mq_inst.push_back(f(oaddr));
               end
            end
         end
         if (qhs) begin
            outst = 1; oaddr = exp_fetch; stale = 0;
         end
         if (bus.redirect_valid) begin
            mq_pc.delete(); mq_inst.delete();
            exp_fetch = {bus.redirect_pc[31:2], 2'b00};
            if (outst) stale = 1;
         end
      end
      @(posedge clk);
      rst_at_edge = rst;
      #1;
      if (rst) begin
         c_busy = 0;
         bus.from_icache_rsp_valid = 0;
      end else begin
         if (got_rsp) begin
            bus.from_icache_rsp_valid = 0;
            c_busy = 0;
         end
         if (got_req) begin
            c_busy = 1; c_addr = s_req_addr; c_cnt = c_lat;
         end
         if (c_busy && !bus.from_icache_rsp_valid && !(hold_en && c_addr == hold_addr)) begin
            if (c_cnt <= 1) begin
               bus.from_icache_rsp_valid = 1;
               bus.from_icache_rsp_data  = f(c_addr);
            end else begin
               c_cnt--;
            end
         end
      end
   endtask

   task automatic do_reset();
      rst = 1;
      tick(); tick();
      rst = 0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      bit found;
      logic [31:0] first_pc, second_pc;
      bus.redirect_valid = 0; bus.redirect_pc = 0;
      bus.from_icache_req_ready = 1; bus.from_icache_rsp_valid = 0;
      bus.from_icache_rsp_data = 0; bus.out_ready = 0;
      rst = 1;
      repeat (2) @(posedge clk);
      #1;
      rst_at_edge = 1;
      do_reset();

      // in-order stream from RESET_PC
      bus.out_ready = 1; pop_log.delete();
      repeat (12) tick();
      for (int i = 0; i < 4; i++) chk($sformatf("t1_pc%0d", i), logat(i), 32'(i * 4));

      // stalled decode fills the queue
      do_reset();
      bus.out_ready = 0; n_req = 0;
      repeat (20) tick();
      chk("t2_nreq", n_req, 4);
      chk("t2_req_valid_full", s_req_valid, 0);
      chk("t2_head_pc", s_out_pc, 0);
      bus.out_ready = 1; pop_log.delete();
      tick();
      bus.out_ready = 0;
      tick();
      chk("t2_popped_pc", logat(0), 0);
      chk("t2_req_valid", s_req_valid, 1);
      chk("t2_req_addr", s_req_addr, 32'd16);

      // redirect while waiting for pc 8
      do_reset();
      bus.out_ready = 1; hold_en = 1; hold_addr = 32'd8; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_req_hs && s_req_addr == 32'd8) found = 1;
      end
      chk("t3_req8_seen", found, 1);
      tick(); tick();
      chk("t3_rsp_ready_wait", s_rsp_ready, 1);
      chk("t3_addr_wait", s_req_addr, 32'd8);
      bus.redirect_valid = 1; bus.redirect_pc = 32'h1002;
      tick();
      bus.redirect_valid = 0;
      tick();
      chk("t3_addr_discard", s_req_addr, 32'd8);
      chk("t3_req_valid_discard", s_req_valid, 0);
      hold_en = 0; found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (s_req_valid) found = 1;
      end
      chk("t3_req_after", found, 1);
      chk("t3_next_addr", s_req_addr, 32'h1000);
      chk("t3_q_empty", s_out_valid, 0);

      // redirect coincident with the pc 4 response
      do_reset();
      bus.out_ready = 1; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_req_hs && s_req_addr == 32'd4) found = 1;
      end
      chk("t4_req4_seen", found, 1);
      pop_log.delete();
      bus.redirect_valid = 1; bus.redirect_pc = 32'h2000;
      tick();
      bus.redirect_valid = 0;
      tick();
      chk("t4_no_discard", s_rsp_ready, 0);
      chk("t4_req_valid", s_req_valid, 1);
      chk("t4_next_addr", s_req_addr, 32'h2000);
      repeat (3) tick();
      chk("t4_first_pop", logat(0), 32'h2000);

      // address wrap at top of memory
      bus.redirect_valid = 1; bus.redirect_pc = 32'hFFFF_FFFF;
      tick();
      bus.redirect_valid = 0;
      pop_log.delete(); found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_req_hs && s_req_addr == 32'hFFFF_FFFC) found = 1;
      end
      chk("t5_top_req", found, 1);
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (s_req_valid) found = 1;
      end
      chk("t5_req_after", found, 1);
      chk("t5_wrap_addr", s_req_addr, 32'h0);
      repeat (3) tick();
      chk("t5_first_pop", logat(0), 32'hFFFF_FFFC);

      // response-to-out_valid latency with empty queue
      do_reset();
      bus.out_ready = 1; found = 0;
      for (int i = 0; i < 20 && !found; i++) begin
         tick();
         if (s_rsp_valid) found = 1;
      end
      chk("t6_rsp_seen", found, 1);
      first_pc = s_out_pc;
      chk("t6_same_cycle", s_out_valid, BYP);
      tick();
      second_pc = s_out_pc;
      chk("t6_next_cycle", s_out_valid, !BYP);
      chk("t6_pc", BYP ? first_pc : second_pc, 32'h0);

      // mixed traffic against the model
      do_reset();
      for (int i = 0; i < 300; i++) begin
         bus.out_ready             = ($urandom_range(0, 3) != 0);
         bus.from_icache_req_ready = ($urandom_range(0, 3) != 0);
         bus.redirect_valid        = ($urandom_range(0, 15) == 0);
         bus.redirect_pc           = $urandom;
         c_lat                     = $urandom_range(1, 3);
         tick();
      end
      bus.redirect_valid = 0;

      // reset mid-traffic abandons the request
      rst = 1;
      tick(); tick();
      rst = 0;
      bus.from_icache_req_ready = 1; bus.out_ready = 1;
      repeat (6) tick();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
`default_nettype wire

// File: doc/ifetch_queue.md
IFETCH_QUEUE -- requirements
Module: ifetch_queue

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000: first fetch address after reset.
REQ-002 Parameter DEPTH, default 4: instruction queue entries, power of two, 2..16.
REQ-003 clk  in  1  clock; all state changes on its rising edge.
REQ-004 rst  in  1  reset, synchronous, active-high.
REQ-005 redirect_valid  in  1  pipeline redirect (branch/jump/exception).
REQ-006 redirect_pc  in  32  new fetch address; bits [1:0] ignored and forced to 0.
REQ-007 to_icache_req_valid  out  1  fetch request valid.
REQ-008 to_icache_req_addr  out  32  fetch address, word aligned.
REQ-009 from_icache_req_ready  in  1  I-cache accepts request.
REQ-010 from_icache_rsp_valid  in  1  I-cache instruction valid.
REQ-011 from_icache_rsp_data  in  32  instruction word.
REQ-012 to_icache_rsp_ready  out  1  queue accepts instruction.
REQ-013 out_valid  out  1  queue head valid to decode.
REQ-014 out_inst  out  32  head instruction.
REQ-015 out_pc  out  32  head instruction address.
REQ-016 out_ready  in  1  decode consumes head.

Function
REQ-017 The block SHALL implement FSM states REQ, WAIT_RSP and DISCARD, entering REQ on reset.
REQ-018 In REQ, to_icache_req_valid SHALL equal (count < DEPTH); a request handshake (valid & ready) SHALL move to WAIT_RSP.
REQ-019 to_icache_req_addr SHALL be driven from a registered fetch_addr and SHALL stay constant from request assertion until the matching response handshake completes, including in DISCARD, because the I-cache decodes the address throughout the transaction.
REQ-020 In WAIT_RSP and DISCARD, to_icache_rsp_ready SHALL be 1; otherwise 0.
REQ-021 A WAIT_RSP response handshake SHALL push {fetch_addr, rsp_data} into the queue, set fetch_addr to fetch_addr+4 (mod 2^32, 32'hFFFF_FFFC wraps to 0) and return to REQ.
REQ-022 At most one I-cache request SHALL be outstanding; the slot reserved at request time guarantees the push never overflows.
REQ-023 Queue SHALL be FIFO-ordered, with count in 0..DEPTH; out_valid = (count != 0); a pop occurs on out_valid & out_ready.
REQ-024 Simultaneous push and pop SHALL leave count unchanged and lose no entry, including at count == DEPTH.
REQ-025 redirect_valid SHALL flush the queue to count 0 and load next_pc = {redirect_pc[31:2], 2'b00}; it SHALL take priority over push and pop in the same cycle.
REQ-026 On redirect in REQ without handshake, fetch_addr SHALL load next_pc and the state SHALL stay REQ.
REQ-027 On redirect in REQ with a handshake in the same cycle, or in WAIT_RSP with no response handshake, the state SHALL move to DISCARD with next_pc held pending.
REQ-028 On redirect in WAIT_RSP coincident with a response handshake, the response SHALL be dropped, fetch_addr SHALL load next_pc and the state SHALL move to REQ.
REQ-029 In DISCARD, the response handshake SHALL drop the data, load fetch_addr from the pending PC and move to REQ.
REQ-030 A further redirect in DISCARD SHALL overwrite the pending PC.
REQ-031 out_pc/out_inst SHALL be the queue head; they SHALL be held stable while out_valid & ~out_ready.

Reset
REQ-032 While rst = 1: state = REQ, fetch_addr = RESET_PC, count = 0, to_icache_req_valid = 0, to_icache_rsp_ready = 0, out_valid = 0, out_inst = 0, out_pc = 0.
REQ-033 Reset mid-transaction SHALL abandon the outstanding request without discard, since the I-cache is reset by the same rst.

Configuration
REQ-034 Macro IFQ_BYPASS_EN: when defined, a WAIT_RSP response arriving with count == 0 SHALL drive out_valid/out_inst/out_pc combinationally in the same cycle; if out_ready = 1 it is consumed and not pushed.
REQ-035 When IFQ_BYPASS_EN is undefined, every instruction SHALL pass through the queue, giving a minimum response-to-out_valid latency of 1 cycle and no combinational path from from_icache_rsp_* to out_*.

Verification
REQ-036 Reset release, RESET_PC = 0, cache always ready with rsp one cycle after the request -> out_pc sequence 0, 4, 8, 12, instructions in order.
REQ-037 out_ready = 0, DEPTH = 4 -> exactly 4 requests issued, then req_valid = 0; out_ready = 1 -> head pc 0 popped, request for pc 16 issued.
REQ-038 Redirect to 32'h1002 during WAIT_RSP for pc 8 -> req_addr stays 8 until the response, that response is dropped, next request addr = 32'h1000, queue empty.
REQ-039 Redirect coincident with the response handshake for pc 4 -> response dropped, next request addr = redirect target, no DISCARD cycle.
REQ-040 fetch_addr = 32'hFFFF_FFFC -> after the response, next request addr = 0.
REQ-041 IFQ_BYPASS_EN defined, queue empty, out_ready = 1 -> out_valid in the same cycle as rsp_valid and count stays 0; undefined -> out_valid one cycle later.
